vga_timing_gen: RTL

Parametrised VGA raster timing generator with a pixel-request interface and a latency-matched colour output stage. It replaces fixed 640x480 timing with generic horizontal/vertical timing, selectable sync polarity, and pixel coordinates for an upstream pixel source (snake board renderer). Syncs, data-enable and colour are delayed by a configurable source latency so they arrive aligned at the DAC pins.

---
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
// Pixel-request and display-pin bundle of the VGA timing generator.
//   master (generator): drives px_x/px_y/px_valid/frame_start toward the
//                       pixel source and the registered colour/sync pins;
//                       receives rbg from the source.
//   slave  (source/DAC side): the mirror image.
//   px_x, px_y  : request coordinate (raw h/v counters)
//   px_valid    : coordinate lies inside the active area
//   frame_start : one-cycle strobe at coordinate (0,0)
//   rbg         : source colour, [11:8] red, [7:4] blue, [3:0] green
//   red_out/blue_out/green_out, hSync, vSync : registered pin outputs
interface vga_timing_gen_if #(
    parameter int COORD_W = 10
);
    logic [COORD_W-1:0] px_x;
    logic [COORD_W-1:0] px_y;
    logic               px_valid;
    logic               frame_start;
    logic [11:0]        rbg;
    logic [3:0]         red_out;
    logic [3:0]         blue_out;
    logic [3:0]         green_out;
    logic               hSync;
    logic               vSync;

    modport master (
        output px_x, px_y, px_valid, frame_start,
        output red_out, blue_out, green_out, hSync, vSync,
        input  rbg
    );

    modport slave (
        input  px_x, px_y, px_valid, frame_start,
        input  red_out, blue_out, green_out, hSync, vSync,
        output rbg
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Generic VGA raster timing generator. Free-running h/v counters give the
// request coordinate for an upstream pixel source; sync/data-enable terms are
// delayed by PIX_LAT cycles so they meet the source's colour in a final
// output register, keeping syncs, blanking and colour aligned at the pins.
//   clk25 : pixel clock (rising edge)
//   rst_n : asynchronous active-low reset
//   vga   : master side of vga_timing_gen_if (coordinates out, rbg in,
//           registered colour and syncs out)
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIX_LAT  = 1,
    parameter int COORD_W  = 10
) (
    input  logic             clk25,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_last;
    logic               v_last;

    assign h_last = (h_cnt == COORD_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == COORD_W'(V_TOTAL - 1));

    // v_cnt advances only on the h wrap, so (H_TOTAL-1, V_TOTAL-1) -> (0,0)
    // happens in a single step.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + COORD_W'(1);
        end else begin
            h_cnt <= h_cnt + COORD_W'(1);
        end
    end

    logic hs_act;
    logic vs_act;
    logic de;

    assign de     = (h_cnt < COORD_W'(H_ACTIVE)) && (v_cnt < COORD_W'(V_ACTIVE));
    assign hs_act = (h_cnt >= COORD_W'(H_ACTIVE + H_FP)) &&
                    (h_cnt <  COORD_W'(H_ACTIVE + H_FP + H_SYNC));
    // Depends only on v_cnt, so it spans whole lines.
    assign vs_act = (v_cnt >= COORD_W'(V_ACTIVE + V_FP)) &&
                    (v_cnt <  COORD_W'(V_ACTIVE + V_FP + V_SYNC));

    assign vga.px_x        = h_cnt;
    assign vga.px_y        = v_cnt;
    assign vga.px_valid    = de;
    assign vga.frame_start = (h_cnt == '0) && (v_cnt == '0);

    // {hs, vs, de} delayed to match the source latency. Reset fills the
    // line with inactive terms so nothing stale reaches the pins.
    logic [2:0] cur_terms;
    logic [2:0] dly_terms;

    assign cur_terms = {hs_act, vs_act, de};

    if (PIX_LAT == 0) begin : g_nodly
        assign dly_terms = cur_terms;
    end else begin : g_dly
        logic [2:0] term_pipe [PIX_LAT];

        always_ff @(posedge clk25 or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIX_LAT; i++) term_pipe[i] <= '0;
            end else begin
                term_pipe[0] <= cur_terms;
                for (int i = 1; i < PIX_LAT; i++) term_pipe[i] <= term_pipe[i-1];
            end
        end

        assign dly_terms = term_pipe[PIX_LAT-1];
    end

    // Pin register: the delayed de blanks colour; syncs get their polarity.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            vga.hSync     <= ~H_POL;
            vga.vSync     <= ~V_POL;
            vga.red_out   <= '0;
            vga.blue_out  <= '0;
            vga.green_out <= '0;
        end else begin
            vga.hSync     <= dly_terms[2] ? H_POL : ~H_POL;
            vga.vSync     <= dly_terms[1] ? V_POL : ~V_POL;
            vga.red_out   <= dly_terms[0] ? vga.rbg[11:8] : 4'h0;
            vga.blue_out  <= dly_terms[0] ? vga.rbg[7:4]  : 4'h0;
            vga.green_out <= dly_terms[0] ? vga.rbg[3:0]  : 4'h0;
        end
    end
endmodule
